// File: rtl/uart_tx_scheduler.sv
// Two-requester scheduler that feeds one UART transmitter: arbitrate, load, frame, then inter-frame gap.
// Build with UART_SCHED_FAIRNESS_EN defined for round-robin arbitration; otherwise requester 0 has fixed priority.
module uart_tx_scheduler #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FRAME_BITS   = 11,
    parameter int GAP_BITS     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  data0,
    input  logic [7:0]  data1,
    output logic        ack0,
    output logic        ack1,
    output logic [1:0]  grant,
    output logic [7:0]  data_uart,
    output logic        idle_uart,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_GAP} state_e;

    localparam logic [7:0] LAST_CYC   = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] LAST_FRAME = 8'(FRAME_BITS - 1);
    localparam logic [7:0] LAST_GAP   = 8'(GAP_BITS - 1);

    state_e      state_q, state_d;
    logic [7:0]  cyc_cnt_q, cyc_cnt_d;
    logic [7:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  grant_q, grant_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        any_req, win1, bit_end, send_done, gap_done;

    assign any_req   = req0 | req1;
    assign bit_end   = (cyc_cnt_q == LAST_CYC);
    assign send_done = (state_q == ST_SEND) && bit_end && (bit_cnt_q == LAST_FRAME);
    assign gap_done  = (state_q == ST_GAP) && bit_end && (bit_cnt_q == LAST_GAP);

`ifdef UART_SCHED_FAIRNESS_EN
    logic rr_q, rr_d;  // 1 = requester 1 wins a tie; moves only when a grant is issued

    assign win1 = req1 & (~req0 | rr_q);

    always_ff @(posedge clk) begin
        if (rst) rr_q <= 1'b0;
        else     rr_q <= rr_d;
    end

    always_comb begin
        rr_d = rr_q;
        if (state_q == ST_IDLE && any_req) rr_d = ~win1;
    end
`else
    assign win1 = req1 & ~req0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, with the reset branch first.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_req)   state_d = ST_LOAD;
            ST_LOAD:                state_d = ST_SEND;
            ST_SEND: if (send_done) state_d = ST_GAP;
            ST_GAP:  if (gap_done)  state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ack0      = 1'b0;
        ack1      = 1'b0;
        idle_uart = 1'b1;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: busy = 1'b0;
            ST_LOAD: begin
                ack0 = grant_q[0];
                ack1 = grant_q[1];
            end
            ST_SEND: idle_uart = 1'b0;
            default: ;
        endcase
    end

    // Counters restart from zero on every SEND/GAP entry, so they idle at zero elsewhere.
    always_comb begin
        cyc_cnt_d   = 8'd0;
        bit_cnt_d   = 8'd0;
        grant_d     = grant_q;
        data_d      = data_q;
        frame_cnt_d = frame_cnt_q;
        if ((state_q == ST_SEND || state_q == ST_GAP) && !send_done && !gap_done) begin
            if (bit_end) begin
                bit_cnt_d = bit_cnt_q + 8'd1;
            end else begin
                cyc_cnt_d = cyc_cnt_q + 8'd1;
                bit_cnt_d = bit_cnt_q;
            end
        end
        if (state_q == ST_IDLE && any_req) begin
            grant_d = win1 ? 2'b10 : 2'b01;
            data_d  = win1 ? data1 : data0;
        end
        if (send_done) frame_cnt_d = frame_cnt_q + 16'd1;
        if (gap_done)  grant_d     = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt_q   <= 8'd0;
            bit_cnt_q   <= 8'd0;
            grant_q     <= 2'b00;
            data_q      <= 8'h00;
            frame_cnt_q <= 16'd0;
        end else begin
            cyc_cnt_q   <= cyc_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            grant_q     <= grant_d;
            data_q      <= data_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign grant     = grant_q;
    assign data_uart = data_q;
    assign frame_cnt = frame_cnt_q;

endmodule
